// File: rtl/decode_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for the decode stage.
// slave = the decode stage itself; master = the surrounding pipeline.
interface decode_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [XLEN-1:0]  out_imm;
    logic             out_write_enable;
    logic             out_mem_write_enable;
    logic             out_mem_to_reg;
    logic             out_alu_src;
    logic             out_branch;
    logic             out_jump;
    logic             out_jalr;
    logic [3:0]       out_alu_op;
    logic [2:0]       out_funct3;
    logic             out_invalid;
    logic [CNT_W-1:0] illegal_count;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
               out_write_enable, out_mem_write_enable, out_mem_to_reg, out_alu_src,
               out_branch, out_jump, out_jalr, out_alu_op, out_funct3, out_invalid,
               illegal_count
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
               out_write_enable, out_mem_write_enable, out_mem_to_reg, out_alu_src,
               out_branch, out_jump, out_jalr, out_alu_op, out_funct3, out_invalid,
               illegal_count
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes fetch instruction into a registered control/immediate bundle.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; bundle held stable while out_ready is low.
module decode_stage #(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 0,
    parameter int CNT_W    = 16
) (
    input  logic    clk,
    input  logic    rst,
    decode_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_SLL = 4'b0010,
                           OP_SLT = 4'b0011, OP_SLTU = 4'b0100, OP_XOR = 4'b0101,
                           OP_SRL = 4'b0110, OP_SRA = 4'b0111, OP_OR = 4'b1000,
                           OP_AND = 4'b1001, OP_MUL = 4'b1010, OP_PASSB = 4'b1011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic            we;
        logic            mem_we;
        logic            mem_to_reg;
        logic            alu_src;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic [3:0]      alu_op;
        logic [2:0]      funct3;
        logic            invalid;
    } bundle_t;

    bundle_t           dec;
    bundle_t           out_q;
    logic              valid_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;
    logic signed [31:0] imm32;
    logic [6:0]        opcode;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [31:0]       instr;

    // funct3 to ALU op for the shared OP / OP-IMM encodings (funct7 variants handled by caller)
    function automatic logic [3:0] base_op(input logic [2:0] fn3);
        case (fn3)
            3'b000:  base_op = OP_ADD;
            3'b001:  base_op = OP_SLL;
            3'b010:  base_op = OP_SLT;
            3'b011:  base_op = OP_SLTU;
            3'b100:  base_op = OP_XOR;
            3'b101:  base_op = OP_SRL;
            3'b110:  base_op = OP_OR;
            default: base_op = OP_AND;
        endcase
    endfunction

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    always_comb begin
        dec        = '0;
        imm32      = '0;
        dec.pc     = bus.in_pc;
        dec.rd     = instr[11:7];
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.funct3 = f3;
        case (opcode)
            7'b0110011: begin
                dec.we = 1'b1;
                if (f7 == 7'b0000000)                             dec.alu_op = base_op(f3);
                else if (f7 == 7'b0100000 && f3 == 3'b000)        dec.alu_op = OP_SUB;
                else if (f7 == 7'b0100000 && f3 == 3'b101)        dec.alu_op = OP_SRA;
                else if (ENABLE_M != 0 && f7 == 7'b0000001 && f3 == 3'b000) dec.alu_op = OP_MUL;
                else                                              dec.invalid = 1'b1;
            end
            7'b0010011: begin
                dec.we      = 1'b1;
                dec.alu_src = 1'b1;
                imm32       = {{20{instr[31]}}, instr[31:20]};
                if (f3 == 3'b001)
                    dec.invalid = (f7 != 7'b0000000);
                if (f3 == 3'b101 && f7 == 7'b0100000)
                    dec.alu_op = OP_SRA;
                else if (f3 == 3'b101 && f7 != 7'b0000000)
                    dec.invalid = 1'b1;
                else
                    dec.alu_op = base_op(f3);
            end
            7'b0000011: begin
                dec.we         = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src    = 1'b1;
                imm32          = {{20{instr[31]}}, instr[31:20]};
            end
            7'b0100011: begin
                dec.mem_we  = 1'b1;
                dec.alu_src = 1'b1;
                imm32       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            7'b1100011: begin
                dec.branch  = 1'b1;
                dec.alu_op  = OP_SUB;
                dec.invalid = (f3 == 3'b010) || (f3 == 3'b011);
                imm32       = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            7'b1101111: begin
                dec.we   = 1'b1;
                dec.jump = 1'b1;
                imm32    = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            7'b1100111: begin
                dec.we      = 1'b1;
                dec.jalr    = 1'b1;
                dec.alu_src = 1'b1;
                dec.invalid = (f3 != 3'b000);
                imm32       = {{20{instr[31]}}, instr[31:20]};
            end
            7'b0110111: begin
                dec.we      = 1'b1;
                dec.alu_src = 1'b1;
                dec.alu_op  = OP_PASSB;
                imm32       = {instr[31:12], 12'b0};
            end
            7'b0010111: begin
                dec.we      = 1'b1;
                dec.alu_src = 1'b1;
                imm32       = {instr[31:12], 12'b0};
            end
            default: dec.invalid = 1'b1;
        endcase
        dec.imm = XLEN'(imm32);
        // An invalid instruction must not cause any side effect downstream
        if (dec.invalid) begin
            dec.we         = 1'b0;
            dec.mem_we     = 1'b0;
            dec.mem_to_reg = 1'b0;
            dec.alu_src    = 1'b0;
            dec.branch     = 1'b0;
            dec.jump       = 1'b0;
            dec.jalr       = 1'b0;
            dec.alu_op     = OP_ADD;
            dec.imm        = '0;
        end
    end

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (bus.flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
                out_q   <= dec;
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end
            if (accept && dec.invalid && cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.out_valid            = valid_q;
    assign bus.out_pc               = out_q.pc;
    assign bus.out_rd               = out_q.rd;
    assign bus.out_rs1              = out_q.rs1;
    assign bus.out_rs2              = out_q.rs2;
    assign bus.out_imm              = out_q.imm;
    assign bus.out_write_enable     = out_q.we;
    assign bus.out_mem_write_enable = out_q.mem_we;
    assign bus.out_mem_to_reg       = out_q.mem_to_reg;
    assign bus.out_alu_src          = out_q.alu_src;
    assign bus.out_branch           = out_q.branch;
    assign bus.out_jump             = out_q.jump;
    assign bus.out_jalr             = out_q.jalr;
    assign bus.out_alu_op           = out_q.alu_op;
    assign bus.out_funct3           = out_q.funct3;
    assign bus.out_invalid          = out_q.invalid;
    assign bus.illegal_count        = cnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench: three decode_stage copies (base, M-enabled, 2-bit counter) share one stimulus.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    decode_if #(.XLEN(32), .CNT_W(16)) i0 ();
    decode_if #(.XLEN(32), .CNT_W(16)) i1 ();
    decode_if #(.XLEN(32), .CNT_W(2))  i2 ();

    assign i1.in_valid = i0.in_valid;
    assign i1.in_instr = i0.in_instr;
    assign i1.in_pc    = i0.in_pc;
    assign i1.flush    = i0.flush;
    assign i1.out_ready = i0.out_ready;
    assign i2.in_valid = i0.in_valid;
    assign i2.in_instr = i0.in_instr;
    assign i2.in_pc    = i0.in_pc;
    assign i2.flush    = i0.flush;
    assign i2.out_ready = i0.out_ready;

    decode_stage #(.XLEN(32), .ENABLE_M(0), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(i0));
    decode_stage #(.XLEN(32), .ENABLE_M(1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(i1));
    decode_stage #(.XLEN(32), .ENABLE_M(0), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(i2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic fl, input logic rdy);
        i0.in_valid  = v;
        i0.in_instr  = ins;
        i0.in_pc     = pc;
        i0.flush     = fl;
        i0.out_ready = rdy;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", i0.out_valid, 0);
        chk("rst_count", i0.illegal_count, 0);
        chk("rst_imm", i0.out_imm, 0);
        chk("rst_rd", i0.out_rd, 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", i0.in_ready, 1);
        @(negedge clk);

        // add x3,x1,x2
        drive(1'b1, 32'h002081B3, 32'h100, 1'b0, 1'b1);
        tick();
        chk("add_valid", i0.out_valid, 1);
        chk("add_rd", i0.out_rd, 3);
        chk("add_rs1", i0.out_rs1, 1);
        chk("add_rs2", i0.out_rs2, 2);
        chk("add_alu", i0.out_alu_op, 4'b0000);
        chk("add_we", i0.out_write_enable, 1);
        chk("add_src", i0.out_alu_src, 0);
        chk("add_pc", i0.out_pc, 32'h100);

        // sub x1,x2,x3
        drive(1'b1, 32'h403100B3, 32'h104, 1'b0, 1'b1);
        tick();
        chk("sub_alu", i0.out_alu_op, 4'b0001);
        chk("sub_rd", i0.out_rd, 1);
        chk("sub_pc", i0.out_pc, 32'h104);

        // sra x1,x2,x3
        drive(1'b1, 32'h403150B3, 32'h108, 1'b0, 1'b1);
        tick();
        chk("sra_alu", i0.out_alu_op, 4'b0111);

        // beq x0,x0,-4
        drive(1'b1, 32'hFE000EE3, 32'h10C, 1'b0, 1'b1);
        tick();
        chk("beq_branch", i0.out_branch, 1);
        chk("beq_alu", i0.out_alu_op, 4'b0001);
        chk("beq_imm", i0.out_imm, 32'hFFFFFFFC);
        chk("beq_we", i0.out_write_enable, 0);

        // sw x1,8(x2)
        drive(1'b1, 32'h00112423, 32'h110, 1'b0, 1'b1);
        tick();
        chk("sw_mem_we", i0.out_mem_write_enable, 1);
        chk("sw_imm", i0.out_imm, 8);
        chk("sw_we", i0.out_write_enable, 0);
        chk("sw_funct3", i0.out_funct3, 3'b010);
        chk("sw_src", i0.out_alu_src, 1);

        // addi x5,x0,-1
        drive(1'b1, 32'hFFF00293, 32'h114, 1'b0, 1'b1);
        tick();
        chk("addi_imm", i0.out_imm, 32'hFFFFFFFF);
        chk("addi_rd", i0.out_rd, 5);
        chk("addi_src", i0.out_alu_src, 1);

        // lui x1,0x12345
        drive(1'b1, 32'h123450B7, 32'h118, 1'b0, 1'b1);
        tick();
        chk("lui_imm", i0.out_imm, 32'h12345000);
        chk("lui_alu", i0.out_alu_op, 4'b1011);

        // jal x0,8
        drive(1'b1, 32'h0080006F, 32'h11C, 1'b0, 1'b1);
        tick();
        chk("jal_jump", i0.out_jump, 1);
        chk("jal_imm", i0.out_imm, 8);
        chk("jal_we", i0.out_write_enable, 1);

        // mul x0,x1,x2: illegal without M, MUL with M
        drive(1'b1, 32'h02208033, 32'h120, 1'b0, 1'b1);
        tick();
        chk("mul0_invalid", i0.out_invalid, 1);
        chk("mul0_we", i0.out_write_enable, 0);
        chk("mul0_count", i0.illegal_count, 1);
        chk("mul1_alu", i1.out_alu_op, 4'b1010);
        chk("mul1_invalid", i1.out_invalid, 0);
        chk("mul1_count", i1.illegal_count, 0);

        drive(1'b1, 32'h00000000, 32'h124, 1'b0, 1'b1);
        tick();
        chk("ill0_invalid", i0.out_invalid, 1);
        chk("ill0_imm", i0.out_imm, 0);
        chk("ill0_count", i0.illegal_count, 2);
        drive(1'b1, 32'hFFFFFFFF, 32'h128, 1'b0, 1'b1);
        tick();
        chk("ill1_count2", i2.illegal_count, 3);
        drive(1'b1, 32'h80000033, 32'h12C, 1'b0, 1'b1);
        tick();
        chk("badf7_invalid", i0.out_invalid, 1);
        chk("ill2_count", i0.illegal_count, 4);
        chk("sat_count2", i2.illegal_count, 3);
        chk("m_count", i1.illegal_count, 3);

        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        chk("idle_valid", i0.out_valid, 0);

        // Backpressure: A accepted, B stalled, then B and C drain in order
        drive(1'b1, 32'h00100093, 32'h200, 1'b0, 1'b0);
        tick();
        chk("bp_a_valid", i0.out_valid, 1);
        chk("bp_a_rd", i0.out_rd, 1);
        chk("bp_in_ready", i0.in_ready, 0);
        drive(1'b1, 32'h00200113, 32'h204, 1'b0, 1'b0);
        tick();
        chk("bp_hold_rd", i0.out_rd, 1);
        chk("bp_hold_imm", i0.out_imm, 1);
        chk("bp_hold_pc", i0.out_pc, 32'h200);
        tick();
        chk("bp_hold2_rd", i0.out_rd, 1);
        drive(1'b1, 32'h00200113, 32'h204, 1'b0, 1'b1);
        #1;
        chk("bp_rel_ready", i0.in_ready, 1);
        tick();
        chk("bp_b_rd", i0.out_rd, 2);
        chk("bp_b_pc", i0.out_pc, 32'h204);
        drive(1'b1, 32'h00300193, 32'h208, 1'b0, 1'b1);
        tick();
        chk("bp_c_rd", i0.out_rd, 3);
        chk("bp_c_valid", i0.out_valid, 1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        chk("bp_drained", i0.out_valid, 0);

        // Flush with held bundle and an incoming illegal instruction
        drive(1'b1, 32'h002081B3, 32'h300, 1'b0, 1'b0);
        tick();
        chk("fl_pre_valid", i0.out_valid, 1);
        drive(1'b1, 32'h00000000, 32'h304, 1'b1, 1'b0);
        tick();
        chk("fl_valid", i0.out_valid, 0);
        chk("fl_count", i0.illegal_count, 4);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        chk("fl_dropped", i0.out_valid, 0);

        // Asynchronous reset while holding a bundle
        drive(1'b1, 32'h002081B3, 32'h400, 1'b0, 1'b0);
        tick();
        chk("ar_pre_valid", i0.out_valid, 1);
        rst = 1'b1;
        #1;
        chk("ar_valid", i0.out_valid, 0);
        chk("ar_rd", i0.out_rd, 0);
        chk("ar_we", i0.out_write_enable, 0);
        chk("ar_pc", i0.out_pc, 0);
        chk("ar_count", i0.illegal_count, 0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
